// File: rtl/lsb_msb_cnt_ctrl_if.sv
// Control/status bundle between the run sequencer and its tick source / readout logic.
// The preload signals exist only when CNT_CTRL_PRELOAD_EN is defined.
interface lsb_msb_cnt_ctrl_if #(
    parameter int unsigned LSB_W = 12,
    parameter int unsigned MSB_W = 3
);
    logic             start_i;
    logic             stop_i;
    logic             clear_i;
    logic             tick_i;
    logic             done_ack_i;
    logic             busy_o;
    logic             done_o;
    logic             err_o;
    logic [LSB_W-1:0] lsb_cnt_o;
    logic [MSB_W-1:0] msb_cnt_o;
`ifdef CNT_CTRL_PRELOAD_EN
    logic             load_i;
    logic [LSB_W-1:0] load_lsb_i;
    logic [MSB_W-1:0] load_msb_i;
`endif

    modport master (
`ifdef CNT_CTRL_PRELOAD_EN
        output load_i, load_lsb_i, load_msb_i,
`endif
        output start_i, stop_i, clear_i, tick_i, done_ack_i,
        input  busy_o, done_o, err_o, lsb_cnt_o, msb_cnt_o
    );

    modport slave (
`ifdef CNT_CTRL_PRELOAD_EN
        input  load_i, load_lsb_i, load_msb_i,
`endif
        input  start_i, stop_i, clear_i, tick_i, done_ack_i,
        output busy_o, done_o, err_o, lsb_cnt_o, msb_cnt_o
    );
endinterface

// File: rtl/lsb_msb_cnt_ctrl.sv
// Two-level LSB/MSB counter sequencer with start/pause/clear, done/ack and sticky range error.
// Optional counter preload in IDLE/PAUSE is enabled by defining CNT_CTRL_PRELOAD_EN.
module lsb_msb_cnt_ctrl #(
    parameter int unsigned      LSB_W       = 12,
    parameter int unsigned      MSB_W       = 3,
    parameter logic [LSB_W-1:0] LSB_CNT_MAX = 12'd3999,
    parameter logic [MSB_W-1:0] MSB_TGT     = 3'd7
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    lsb_msb_cnt_ctrl_if.slave   bus
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRun   = 3'd1;
    localparam logic [2:0] StPause = 3'd2;
    localparam logic [2:0] StDone  = 3'd3;
    localparam logic [2:0] StErr   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [LSB_W-1:0] lsb_q, lsb_d;
    logic [MSB_W-1:0] msb_q, msb_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        lsb_d   = lsb_q;
        msb_d   = msb_q;
        done_d  = done_q;
        err_d   = err_q;

        if (bus.clear_i) begin
            state_d = StIdle;
            lsb_d   = '0;
            msb_d   = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
`ifdef CNT_CTRL_PRELOAD_EN
                    if (bus.load_i) begin
                        lsb_d = bus.load_lsb_i;
                        msb_d = bus.load_msb_i;
                    end else
`endif
                    if (bus.start_i) begin
                        lsb_d   = '0;
                        msb_d   = '0;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    // A tick coinciding with stop is dropped.
                    if (bus.stop_i) begin
                        state_d = StPause;
                    end else if (bus.tick_i) begin
                        if (lsb_q > LSB_CNT_MAX) begin
                            err_d   = 1'b1;
                            state_d = StErr;
                        end else if (lsb_q == LSB_CNT_MAX) begin
                            lsb_d = '0;
                            if (msb_q == MSB_TGT) begin
                                done_d  = 1'b1;
                                state_d = StDone;
                            end else begin
                                msb_d = msb_q + 1'b1;
                            end
                        end else begin
                            lsb_d = lsb_q + 1'b1;
                        end
                    end
                end
                StPause: begin
`ifdef CNT_CTRL_PRELOAD_EN
                    if (bus.load_i) begin
                        lsb_d = bus.load_lsb_i;
                        msb_d = bus.load_msb_i;
                    end else
`endif
                    if (bus.start_i && !bus.stop_i) begin
                        state_d = StRun;
                    end
                end
                StDone: begin
                    if (bus.done_ack_i) begin
                        done_d  = 1'b0;
                        state_d = StIdle;
                    end
                end
                StErr: begin
                    state_d = StErr;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end

        busy_d = (state_d == StRun) || (state_d == StPause);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            lsb_q   <= '0;
            msb_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lsb_q   <= lsb_d;
            msb_q   <= msb_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.err_o     = err_q;
    assign bus.lsb_cnt_o = lsb_q;
    assign bus.msb_cnt_o = msb_q;

endmodule

// File: tb/tb_lsb_msb_cnt_ctrl.sv
// Scoreboard bench for lsb_msb_cnt_ctrl: directed scenarios plus random stimulus vs a
// position-based reference model; preload scenario runs when CNT_CTRL_PRELOAD_EN is defined.
module tb_lsb_msb_cnt_ctrl;

    localparam int unsigned    LW   = 12;
    localparam int unsigned    MW   = 3;
    localparam logic [LW-1:0]  LMAX = 12'd3;
    localparam logic [MW-1:0]  TGT  = 3'd2;
    localparam int             N    = 4;
`ifdef CNT_CTRL_PRELOAD_EN
    localparam bit             PRE  = 1'b1;
`else
    localparam bit             PRE  = 1'b0;
`endif

    localparam int MIdle = 0, MRun = 1, MPause = 2, MDone = 3, MErr = 4;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic          err;
        logic [LW-1:0] lsb;
        logic [MW-1:0] msb;
    } obs_t;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b1;
    always #5 clk_i = ~clk_i;

    lsb_msb_cnt_ctrl_if #(.LSB_W(LW), .MSB_W(MW)) bus ();

    lsb_msb_cnt_ctrl #(
        .LSB_W       (LW),
        .MSB_W       (MW),
        .LSB_CNT_MAX (LMAX),
        .MSB_TGT     (TGT)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    obs_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_push = 0;
    int   n_pop  = 0;

    int m_st  = MIdle;
    int m_lsb = 0;
    int m_msb = 0;
    bit m_done = 1'b0;
    bit m_err  = 1'b0;

    function automatic obs_t dut_obs();
        obs_t o;
        o.busy = bus.busy_o;
        o.done = bus.done_o;
        o.err  = bus.err_o;
        o.lsb  = bus.lsb_cnt_o;
        o.msb  = bus.msb_cnt_o;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.busy = (m_st == MRun) || (m_st == MPause);
        o.done = m_done;
        o.err  = m_err;
        o.lsb  = m_lsb[LW-1:0];
        o.msb  = m_msb[MW-1:0];
        return o;
    endfunction

    task automatic check_obs(input string name, input obs_t act, input obs_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got busy=%0b done=%0b err=%0b lsb=%0d msb=%0d, want busy=%0b done=%0b err=%0b lsb=%0d msb=%0d",
                     name, act.busy, act.done, act.err, act.lsb, act.msb,
                     exp.busy, exp.done, exp.err, exp.lsb, exp.msb);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Counter treated as one position msb*N+lsb; a run ends at the last position of MSB_TGT.
    task automatic model_step(input bit st, input bit sp, input bit cl, input bit tk,
                              input bit ak, input bit ld, input int ldl, input int ldm);
        int pos;
        if (cl) begin
            m_st = MIdle; m_lsb = 0; m_msb = 0; m_done = 0; m_err = 0;
        end else begin
            case (m_st)
                MIdle: begin
                    if (PRE && ld) begin
                        m_lsb = ldl; m_msb = ldm;
                    end else if (st) begin
                        m_lsb = 0; m_msb = 0; m_st = MRun;
                    end
                end
                MRun: begin
                    if (sp) m_st = MPause;
                    else if (tk) begin
                        if (m_lsb > int'(LMAX)) begin
                            m_err = 1; m_st = MErr;
                        end else begin
                            pos = m_msb * N + m_lsb + 1;
                            if (pos == (int'(TGT) + 1) * N) begin
                                m_lsb = 0; m_done = 1; m_st = MDone;
                            end else begin
                                m_lsb = pos % N;
                                m_msb = (pos / N) % (1 << MW);
                            end
                        end
                    end
                end
                MPause: begin
                    if (PRE && ld) begin
                        m_lsb = ldl; m_msb = ldm;
                    end else if (st && !sp) m_st = MRun;
                end
                MDone: begin
                    if (ak) begin
                        m_done = 0; m_st = MIdle;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic cyc(input bit st, input bit sp, input bit cl, input bit tk, input bit ak,
                       input bit ld = 1'b0, input int ldl = 0, input int ldm = 0);
        bus.start_i    = st;
        bus.stop_i     = sp;
        bus.clear_i    = cl;
        bus.tick_i     = tk;
        bus.done_ack_i = ak;
`ifdef CNT_CTRL_PRELOAD_EN
        bus.load_i     = ld;
        bus.load_lsb_i = ldl[LW-1:0];
        bus.load_msb_i = ldm[MW-1:0];
`endif
        model_step(st, sp, cl, tk, ak, ld, ldl, ldm);
        exp_q.push_back(model_obs());
        n_push++;
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start_i = 0; bus.stop_i = 0; bus.clear_i = 0; bus.tick_i = 0; bus.done_ack_i = 0;
`ifdef CNT_CTRL_PRELOAD_EN
        bus.load_i = 0; bus.load_lsb_i = '0; bus.load_msb_i = '0;
`endif
    endtask

    // Reset asserted in the high phase; outputs must drop without waiting for a clock edge.
    task automatic hit_reset(input string name);
        idle_inputs();
        model_step(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk_i);
        #2 rst_ni = 1'b0;
        #1;
        m_st = MIdle; m_lsb = 0; m_msb = 0; m_done = 0; m_err = 0;
        check_obs(name, dut_obs(), obs_t'(0));
        repeat (2) @(negedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    always @(negedge clk_i) begin
        obs_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_pop++;
            check_obs("cycle", dut_obs(), e);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        obs_t o;
        idle_inputs();
        // Scenario 1: asynchronous reset from power-up.
        hit_reset("reset_initial");

        // Scenario 2: full run to terminal count.
        cyc(1, 0, 0, 0, 0);
        for (int t = 1; t <= 12; t++) begin
            cyc(0, 0, 0, 1, 0);
            if (t == 4) check_val("msb_after_tick4", int'(bus.msb_cnt_o), 1);
            if (t == 8) check_val("msb_after_tick8", int'(bus.msb_cnt_o), 2);
        end
        o = dut_obs();
        check_val("done_after_12", int'(o.done), 1);
        check_val("lsb_after_12", int'(o.lsb), 0);
        check_val("msb_after_12", int'(o.msb), 2);
        check_val("busy_after_12", int'(o.busy), 0);

        // Scenario 4: done held until acknowledged.
        repeat (10) cyc(0, 0, 0, 1, 0);
        check_val("done_held", int'(bus.done_o), 1);
        cyc(0, 0, 0, 0, 1);
        check_val("done_acked", int'(bus.done_o), 0);
        cyc(0, 0, 0, 1, 0);
        check_val("idle_tick_lsb", int'(bus.lsb_cnt_o), 0);
        check_val("idle_tick_msb", int'(bus.msb_cnt_o), 2);

        // Scenario 3: pause drops ticks, resume continues.
        cyc(1, 0, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 1, 0);
        check_val("run5_lsb", int'(bus.lsb_cnt_o), 1);
        check_val("run5_msb", int'(bus.msb_cnt_o), 1);
        cyc(0, 1, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 1, 0);
        check_val("pause_lsb", int'(bus.lsb_cnt_o), 1);
        check_val("pause_busy", int'(bus.busy_o), 1);
        cyc(1, 1, 0, 0, 0);
        check_val("start_stop_pause_lsb", int'(bus.lsb_cnt_o), 1);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        check_val("resume_lsb", int'(bus.lsb_cnt_o), 2);

        // Scenario 6: reset during run.
        hit_reset("reset_in_run");
        cyc(0, 0, 0, 1, 0);
        check_val("post_reset_tick_lsb", int'(bus.lsb_cnt_o), 0);
        check_val("post_reset_busy", int'(bus.busy_o), 0);

`ifdef CNT_CTRL_PRELOAD_EN
        // Scenario 5: out-of-range preload traps into the sticky error state.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 5, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        check_val("err_set", int'(bus.err_o), 1);
        check_val("err_lsb", int'(bus.lsb_cnt_o), 5);
        cyc(1, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        check_val("err_frozen", int'(bus.lsb_cnt_o), 5);
        cyc(0, 0, 1, 0, 0);
        check_val("err_cleared", int'(bus.err_o), 0);
        check_val("clear_lsb", int'(bus.lsb_cnt_o), 0);
`endif

        // Random phase.
        cyc(0, 0, 1, 0, 0);
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom % 4) == 0, ($urandom % 8) == 0, ($urandom % 40) == 0,
                ($urandom % 2) == 0, ($urandom % 8) == 0,
                ($urandom % 16) == 0, int'($urandom_range(0, 5)), int'($urandom_range(0, 2)));
        end

        idle_inputs();
        @(negedge clk_i);
        #1;
        check_val("queue_drain", n_pop, n_push);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
